// File: rtl/mux_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_if
// Description : Signal bundle between a scan sequencer and the agent that
//               owns the 4:1 mux data path.
//               master : drives start/hold/mux_o, observes select and result
//               slave  : the sequencer (mux_scan_ctrl)
//               Signals: start, hold, mux_o (to sequencer);
//                        j0, j1, word[0:3], busy, done (from sequencer)
// Revision    : 1.0  initial release
// ============================================================================
interface mux_scan_if;
    logic       start;
    logic       hold;
    logic       mux_o;
    logic       j0;
    logic       j1;
    logic [0:3] word;
    logic       busy;
    logic       done;

    modport master (
        output start, hold, mux_o,
        input  j0, j1, word, busy, done
    );

    modport slave (
        input  start, hold, mux_o,
        output j0, j1, word, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps the select lines {j0,j1} of a downstream 4:1 mux through
//               channels 0..3, samples the mux output once per channel and
//               assembles a 4-bit word; done pulses for one cycle when the
//               word is complete.
//               Ports: clk, rst (sync, active-high), bus (mux_scan_if.slave)
//               Parameters: SETTLE - cycles each select is held (>=1)
//                           CONT   - 1: restart automatically after done
// Revision    : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int SETTLE = 1,
    parameter bit CONT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mux_scan_if.slave  bus
);

    localparam int                 c_cnt_w    = $clog2(SETTLE + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [c_cnt_w-1:0] r_cnt;
    logic [0:3]         r_word;

    state_t             w_state;
    logic [1:0]         w_sel;
    logic [c_cnt_w-1:0] w_cnt;
    logic [0:3]         w_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_cnt   <= '0;
            r_word  <= 4'b0000;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_cnt   <= w_cnt;
            r_word  <= w_word;
        end
    end

    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_cnt   = r_cnt;
        w_word  = r_word;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state = ST_SCAN;
                    w_sel   = 2'd0;
                    w_cnt   = '0;
                    w_word  = 4'b0000;
                end
            end

            ST_SCAN: begin
                // hold freezes everything, so each hold cycle adds exactly one
                // cycle of latency.
                if (!bus.hold) begin
                    if (r_cnt == c_cnt_last) begin
                        // Sample on the last cycle the select has been stable.
                        w_word[r_sel] = bus.mux_o;
                        w_cnt         = '0;
                        if (r_sel == 2'd3) begin
                            w_state = ST_DONE;
                            w_sel   = 2'd0;
                        end else begin
                            w_sel = r_sel + 2'd1;
                        end
                    end else begin
                        w_cnt = r_cnt + c_cnt_w'(1);
                    end
                end
            end

            ST_DONE: begin
                // word stays valid through this cycle; a restart clears it
                // on the following edge.
                if (bus.start || CONT) begin
                    w_state = ST_SCAN;
                    w_sel   = 2'd0;
                    w_cnt   = '0;
                    w_word  = 4'b0000;
                end else begin
                    w_state = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_sel   = 2'd0;
                w_cnt   = '0;
            end
        endcase
    end

    assign bus.j0   = r_sel[1];
    assign bus.j1   = r_sel[0];
    assign bus.word = r_word;
    assign bus.busy = (r_state == ST_SCAN);
    assign bus.done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. Three instances:
//               SETTLE=1/CONT=0, SETTLE=3/CONT=0, SETTLE=3/CONT=1. The 4:1
//               mux is modelled as o = i[{j0,j1}]. Expected words are queued
//               when a scan is launched and popped when done pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:3] i   = 4'b0000;

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:3] sb[$];
    logic [0:3] exp_w;

    mux_scan_if bus1 ();
    mux_scan_if bus3 ();
    mux_scan_if bus3c ();

    assign bus1.mux_o  = i[{bus1.j0, bus1.j1}];
    assign bus3.mux_o  = i[{bus3.j0, bus3.j1}];
    assign bus3c.mux_o = i[{bus3c.j0, bus3c.j1}];

    mux_scan_ctrl #(.SETTLE(1), .CONT(1'b0)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
    mux_scan_ctrl #(.SETTLE(3), .CONT(1'b0)) dut3  (.clk(clk), .rst(rst), .bus(bus3));
    mux_scan_ctrl #(.SETTLE(3), .CONT(1'b1)) dut3c (.clk(clk), .rst(rst), .bus(bus3c));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int which);
        case (which)
            1:       return bus1.done;
            3:       return bus3.done;
            default: return bus3c.done;
        endcase
    endfunction

    // Bounded wait for done; cycles = edges taken, -1 if the bound expires.
    task automatic wait_done(input int which, input int bound, output int cycles);
        cycles = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (done_of(which)) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b1; bus3.start = 1'b1; bus3c.start = 1'b1;
        bus1.hold  = 1'b0; bus3.hold  = 1'b0; bus3c.hold  = 1'b0;
        tick();
        tick();
        n_tests++; if ({bus1.j0, bus1.j1, bus1.word, bus1.busy, bus1.done} !== 8'h00) begin
            n_fail++; $display("FAIL reset_dut1: got %b required 00000000", {bus1.j0, bus1.j1, bus1.word, bus1.busy, bus1.done});
        end
        n_tests++; if ({bus3.j0, bus3.j1, bus3.word, bus3.busy, bus3.done} !== 8'h00) begin
            n_fail++; $display("FAIL reset_dut3: got %b required 00000000", {bus3.j0, bus3.j1, bus3.word, bus3.busy, bus3.done});
        end
        n_tests++; if ({bus3c.j0, bus3c.j1, bus3c.word, bus3c.busy, bus3c.done} !== 8'h00) begin
            n_fail++; $display("FAIL reset_dut3c: got %b required 00000000", {bus3c.j0, bus3c.j1, bus3c.word, bus3c.busy, bus3c.done});
        end
        rst = 1'b0;
        bus1.start = 1'b0; bus3.start = 1'b0; bus3c.start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        i = 4'b1010;
        sb.push_back(4'b1010);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n_tests++; if (bus1.busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy: got %b required 1", bus1.busy);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if ({bus1.j0, bus1.j1} !== 2'(k)) begin
                n_fail++; $display("FAIL basic_sel%0d: got %b required %b", k, {bus1.j0, bus1.j1}, 2'(k));
            end
            tick();
        end
        n_tests++; if (bus1.done !== 1'b1 || bus1.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got done=%b busy=%b required done=1 busy=0", bus1.done, bus1.busy);
        end
        exp_w = sb.pop_front();
        n_tests++; if (bus1.word !== exp_w) begin
            n_fail++; $display("FAIL basic_word: got %b required %b", bus1.word, exp_w);
        end
        tick();
        n_tests++; if (bus1.done !== 1'b0 || bus1.word !== exp_w) begin
            n_fail++; $display("FAIL basic_idle: got done=%b word=%b required done=0 word=%b", bus1.done, bus1.word, exp_w);
        end
    endtask

    task automatic test_hold();
        int c;
        i = 4'b0110;
        sb.push_back(4'b0110);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        bus1.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if ({bus1.j0, bus1.j1} !== 2'b01 || bus1.done !== 1'b0) begin
                n_fail++; $display("FAIL hold_sel%0d: got sel=%b done=%b required sel=01 done=0", k, {bus1.j0, bus1.j1}, bus1.done);
            end
        end
        bus1.hold = 1'b0;
        wait_done(1, 10, c);
        n_tests++; if (c !== 3) begin
            n_fail++; $display("FAIL hold_latency: got %0d required 3 more edges (7 total)", c);
        end
        exp_w = sb.pop_front();
        n_tests++; if (bus1.word !== exp_w) begin
            n_fail++; $display("FAIL hold_word: got %b required %b", bus1.word, exp_w);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        i = 4'b1111;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        tick();
        n_tests++; if ({bus1.j0, bus1.j1} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_pre: got %b required 10", {bus1.j0, bus1.j1});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if ({bus1.j0, bus1.j1, bus1.word, bus1.busy, bus1.done} !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_out: got %b required 00000000", {bus1.j0, bus1.j1, bus1.word, bus1.busy, bus1.done});
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus1.done === 1'b1) seen++;
        end
        n_tests++; if (seen !== 0) begin
            n_fail++; $display("FAIL rstmid_nodone: got %0d done pulses required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        i = 4'b1010;
        sb.push_back(4'b1010);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        n_tests++; if ({bus1.j0, bus1.j1} !== 2'b10 || bus1.busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ignore: got sel=%b busy=%b required sel=10 busy=1", {bus1.j0, bus1.j1}, bus1.busy);
        end
        tick();
        tick();
        exp_w = sb.pop_front();
        n_tests++; if (bus1.done !== 1'b1 || bus1.word !== exp_w) begin
            n_fail++; $display("FAIL b2b_done1: got done=%b word=%b required done=1 word=%b", bus1.done, bus1.word, exp_w);
        end
        bus1.start = 1'b1;
        i = 4'b0001;
        sb.push_back(4'b0001);
        tick();
        bus1.start = 1'b0;
        n_tests++; if ({bus1.done, bus1.busy, bus1.j0, bus1.j1, bus1.word} !== 8'b0100_0000) begin
            n_fail++; $display("FAIL b2b_restart: got %b required 01000000", {bus1.done, bus1.busy, bus1.j0, bus1.j1, bus1.word});
        end
        wait_done(1, 10, c);
        n_tests++; if (c !== 4) begin
            n_fail++; $display("FAIL b2b_latency: got %0d required 4", c);
        end
        exp_w = sb.pop_front();
        n_tests++; if (bus1.word !== exp_w) begin
            n_fail++; $display("FAIL b2b_word2: got %b required %b", bus1.word, exp_w);
        end
        tick();
    endtask

    task automatic test_settle3();
        i = 4'b1100;
        sb.push_back(4'b1100);
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            n_tests++; if ({bus3.j0, bus3.j1} !== 2'(k / 3) || bus3.done !== 1'b0) begin
                n_fail++; $display("FAIL settle3_sel%0d: got sel=%b done=%b required sel=%b done=0", k, {bus3.j0, bus3.j1}, bus3.done, 2'(k / 3));
            end
            tick();
        end
        exp_w = sb.pop_front();
        n_tests++; if (bus3.done !== 1'b1 || bus3.word !== exp_w) begin
            n_fail++; $display("FAIL settle3_done: got done=%b word=%b required done=1 word=%b", bus3.done, bus3.word, exp_w);
        end
        tick();
    endtask

    task automatic test_cont();
        int c;
        int exp_c;
        i = 4'b1100;
        for (int k = 0; k < 3; k++) sb.push_back(4'b1100);
        bus3c.start = 1'b1;
        tick();
        bus3c.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_c = (k == 0) ? 12 : 13;
            wait_done(0, 20, c);
            n_tests++; if (c !== exp_c) begin
                n_fail++; $display("FAIL cont_period%0d: got %0d required %0d", k, c, exp_c);
            end
            exp_w = sb.pop_front();
            n_tests++; if (bus3c.word !== exp_w) begin
                n_fail++; $display("FAIL cont_word%0d: got %b required %b", k, bus3c.word, exp_w);
            end
        end
    endtask

    initial begin
        bus1.start = 1'b0; bus3.start = 1'b0; bus3c.start = 1'b0;
        bus1.hold  = 1'b0; bus3.hold  = 1'b0; bus3c.hold  = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_settle3();
        test_cont();
        n_tests++; if (sb.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
